// File: rtl/sprite_redraw_engine.sv
// Erase-then-draw engine for one rectangular object on the frame buffer.
// Emits one pixel per clock, clipping pixels that fall off the visible screen.
module sprite_redraw_engine #(
    parameter int             SCREEN_W  = 160,
    parameter int             SCREEN_H  = 120,
    parameter int             XW        = 8,
    parameter int             YW        = 7,
    parameter int             OBJ_W     = 20,
    parameter int             OBJ_H     = 1,
    parameter int             CW        = 3,
    parameter logic [CW-1:0]  BG_COLOUR = '0
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    // Named force_redraw because force is a reserved word.
    input  logic          force_redraw,
    input  logic          hide,
    input  logic [XW-1:0] obj_x,
    input  logic [YW-1:0] obj_y,
    input  logic [CW-1:0] obj_colour,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          plot
);

    localparam int CXW = (OBJ_W > 1) ? $clog2(OBJ_W) : 1;
    localparam int CYW = (OBJ_H > 1) ? $clog2(OBJ_H) : 1;
    localparam logic [CXW-1:0] CX_LAST = CXW'(OBJ_W - 1);
    localparam logic [CYW-1:0] CY_LAST = CYW'(OBJ_H - 1);
    localparam logic [XW:0]    X_LIM   = (XW+1)'(SCREEN_W);
    localparam logic [YW:0]    Y_LIM   = (YW+1)'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t state, state_nxt;

    logic [XW-1:0]  ox, nx;
    logic [YW-1:0]  oy, ny;
    logic [CW-1:0]  ocol, ncol;
    logic           have_old, nhide;
    logic [CXW-1:0] cx;
    logic [CYW-1:0] cy;

    logic           last_px;
    logic           same_req;
    logic [XW-1:0]  base_x;
    logic [YW-1:0]  base_y;
    logic [XW:0]    sum_x;
    logic [YW:0]    sum_y;

    assign last_px  = (cx == CX_LAST) && (cy == CY_LAST);
    assign same_req = (obj_x == ox) && (obj_y == oy) && (obj_colour == ocol);

    // One extra bit on each sum so off-screen pixels are detected, not wrapped.
    assign base_x = (state == DRAW) ? nx : ox;
    assign base_y = (state == DRAW) ? ny : oy;
    assign sum_x  = {1'b0, base_x} + (XW+1)'(cx);
    assign sum_y  = {1'b0, base_y} + (YW+1)'(cy);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (hide) begin
                        state_nxt = have_old ? ERASE : DONE;
                    end else if (have_old && !force_redraw && same_req) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = have_old ? ERASE : DRAW;
                    end
                end
            end
            ERASE: begin
                if (last_px) begin
                    state_nxt = nhide ? DONE : DRAW;
                end
            end
            DRAW: begin
                if (last_px) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        plot       = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = BG_COLOUR;
        if (state == ERASE || state == DRAW) begin
            vga_x      = sum_x[XW-1:0];
            vga_y      = sum_y[YW-1:0];
            vga_colour = (state == DRAW) ? ncol : BG_COLOUR;
            plot       = (sum_x < X_LIM) && (sum_y < Y_LIM);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ox       <= '0;
            oy       <= '0;
            ocol     <= '0;
            have_old <= 1'b0;
            nx       <= '0;
            ny       <= '0;
            ncol     <= '0;
            nhide    <= 1'b0;
            cx       <= '0;
            cy       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        nx    <= obj_x;
                        ny    <= obj_y;
                        ncol  <= obj_colour;
                        nhide <= hide;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                ERASE, DRAW: begin
                    if (last_px) begin
                        cx <= '0;
                        cy <= '0;
                        if (state == ERASE && nhide) begin
                            have_old <= 1'b0;
                        end
                        if (state == DRAW) begin
                            ox       <= nx;
                            oy       <= ny;
                            ocol     <= ncol;
                            have_old <= 1'b1;
                        end
                    end else if (cx == CX_LAST) begin
                        cx <= '0;
                        cy <= cy + CYW'(1);
                    end else begin
                        cx <= cx + CXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_redraw_engine.sv
// Directed bench for sprite_redraw_engine with default geometry (20x1 object,
// 160x120 screen, 3-bit colour).
module tb_sprite_redraw_engine;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic       force_redraw;
    logic       hide;
    logic [7:0] obj_x;
    logic [6:0] obj_y;
    logic [2:0] obj_colour;
    logic       busy;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;

    int total = 0;
    int bad   = 0;

    // Per-cycle record: {busy, plot, vga_x, vga_y, vga_colour}
    logic [19:0] rec [0:255];
    int          done_cyc;
    int          nplots;

    sprite_redraw_engine dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .force_redraw (force_redraw),
        .hide         (hide),
        .obj_x        (obj_x),
        .obj_y        (obj_y),
        .obj_colour   (obj_colour),
        .busy         (busy),
        .done         (done),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .plot         (plot)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and record every cycle until done (bounded).
    task automatic run_req(input int x, input int y, input int col, input logic frc, input logic hd);
        @(negedge clock);
        obj_x        = 8'(x);
        obj_y        = 7'(y);
        obj_colour   = 3'(col);
        force_redraw = frc;
        hide         = hd;
        start        = 1'b1;
        @(posedge clock);
        #1;
        start        = 1'b0;
        force_redraw = 1'b0;
        hide         = 1'b0;
        done_cyc     = 0;
        nplots       = 0;
        for (int k = 1; k <= 200 && done_cyc == 0; k++) begin
            @(negedge clock);
            rec[k] = {busy, plot, vga_x, vga_y, vga_colour};
            if (plot) nplots++;
            if (done) done_cyc = k;
        end
    endtask

    // Expected pixel run: one row of n pixels starting at (x0, y0).
    task automatic chk_seg(input string tag, input int first, input int n,
                           input int x0, input int y0, input int col);
        for (int i = 0; i < n; i++) begin
            int          x;
            logic [19:0] e;
            x = x0 + i;
            e = {1'b1, (x < 160 && y0 < 120), 8'(x), 7'(y0), 3'(col)};
            chk($sformatf("%s[%0d]", tag, i), 32'(rec[first + i]), 32'(e));
        end
    endtask

    initial begin
        resetn       = 1'b0;
        start        = 1'b0;
        force_redraw = 1'b0;
        hide         = 1'b0;
        obj_x        = '0;
        obj_y        = '0;
        obj_colour   = '0;
        #12;
        chk("reset_ctrl", {busy, done, plot}, 3'b000);
        chk("reset_pix", {vga_x, vga_y, vga_colour}, 18'd0);
        @(negedge clock);
        resetn = 1'b1;

        // First draw: no erase
        run_req(39, 100, 5, 1'b0, 1'b0);
        chk("first_done", done_cyc, 21);
        chk("first_plots", nplots, 20);
        chk_seg("first_draw", 1, 20, 39, 100, 5);

        // Move by one pixel
        run_req(40, 100, 5, 1'b0, 1'b0);
        chk("move_done", done_cyc, 41);
        chk("move_plots", nplots, 40);
        chk_seg("move_erase", 1, 20, 39, 100, 0);
        chk_seg("move_draw", 21, 20, 40, 100, 5);

        // Unchanged request is skipped
        run_req(40, 100, 5, 1'b0, 1'b0);
        chk("skip_done", done_cyc, 1);
        chk("skip_plots", nplots, 0);

        // Same request with force
        run_req(40, 100, 5, 1'b1, 1'b0);
        chk("force_done", done_cyc, 41);
        chk("force_plots", nplots, 40);
        chk_seg("force_erase", 1, 20, 40, 100, 0);
        chk_seg("force_draw", 21, 20, 40, 100, 5);

        // Right-edge clipping
        run_req(150, 100, 5, 1'b0, 1'b0);
        chk("clip_done", done_cyc, 41);
        chk("clip_plots", nplots, 30);
        chk_seg("clip_erase", 1, 20, 40, 100, 0);
        chk_seg("clip_draw", 21, 20, 150, 100, 5);

        // Colour-only change is not skipped
        run_req(150, 100, 2, 1'b0, 1'b0);
        chk("recol_done", done_cyc, 41);
        chk("recol_plots", nplots, 20);
        chk_seg("recol_draw", 21, 20, 150, 100, 2);

        // Hide: erase only
        run_req(0, 0, 7, 1'b0, 1'b1);
        chk("hide_done", done_cyc, 21);
        chk("hide_plots", nplots, 10);
        chk_seg("hide_erase", 1, 20, 150, 100, 0);

        // Hide with nothing visible
        run_req(0, 0, 7, 1'b0, 1'b1);
        chk("hide2_done", done_cyc, 1);
        chk("hide2_plots", nplots, 0);

        // Redraw after hide is a first draw
        run_req(10, 10, 3, 1'b0, 1'b0);
        chk("redraw_done", done_cyc, 21);
        chk("redraw_plots", nplots, 20);
        chk_seg("redraw_draw", 1, 20, 10, 10, 3);

        // Bottom-edge clipping: whole draw row is off-screen
        run_req(10, 125, 4, 1'b0, 1'b0);
        chk("yclip_done", done_cyc, 41);
        chk("yclip_plots", nplots, 20);
        chk_seg("yclip_erase", 1, 20, 10, 10, 0);
        chk_seg("yclip_draw", 21, 20, 10, 125, 4);

        // Reset at the 7th draw pixel
        @(negedge clock);
        obj_x      = 8'd30;
        obj_y      = 7'd50;
        obj_colour = 3'd6;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 27; k++) @(negedge clock);
        chk("mid_px7", {busy, plot, vga_x, vga_y, vga_colour}, {1'b1, 1'b1, 8'd36, 7'd50, 3'd6});
        resetn = 1'b0;
        #1;
        chk("abort_ctrl", {busy, done, plot}, 3'b000);
        @(negedge clock);
        resetn = 1'b1;

        run_req(70, 60, 1, 1'b0, 1'b0);
        chk("post_rst_done", done_cyc, 21);
        chk("post_rst_plots", nplots, 20);
        chk_seg("post_rst_draw", 1, 20, 70, 60, 1);

        // start held high: skip repeats after a single IDLE cycle
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        chk("hold_c1", {busy, done, plot}, 3'b110);
        @(negedge clock);
        chk("hold_c2", {busy, done, plot}, 3'b000);
        @(negedge clock);
        chk("hold_c3", {busy, done, plot}, 3'b110);
        start = 1'b0;
        @(negedge clock);
        chk("hold_c4", {busy, done, plot}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
